tl_ul_sram_responder: RTL and testbench

Single-beat TileLink-UL slave that services Get, PutFullData and PutPartialData against a local word-addressed register array and returns AccessAck/AccessAckData on channel D. It is the responding end of the A/D link that the TL monitor checkers observe. It gives eval and testbench fabrics a well-behaved, protocol-clean target with a 2-entry response queue for backpressure.

---
 rtl/tl_ul_sram_responder.sv | 161 ++++++++++++++++
 tb/tb_tl_ul_sram_responder.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_ul_sram_responder.sv
// tl_ul_sram_responder
// Single-beat TileLink-UL slave: Get / PutFullData / PutPartialData against a
// local word array, answering on channel D through a 2-entry response queue.
// Build option: define TL_UL_RESP_DENY_EN to flag illegal requests with
// d_denied (and d_corrupt on AccessAckData); otherwise they are acked silently.
module tl_ul_sram_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h0800_0000,
   parameter int unsigned DEPTH_WORDS = 256
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic [2:0]  a_opcode,
   input  logic [2:0]  a_param,
   input  logic [3:0]  a_size,
   input  logic [4:0]  a_source,
   input  logic [31:0] a_address,
   input  logic [3:0]  a_mask,
   input  logic [31:0] a_data,
   input  logic        a_corrupt,
   output logic        d_valid,
   input  logic        d_ready,
   output logic [2:0]  d_opcode,
   output logic [1:0]  d_param,
   output logic [3:0]  d_size,
   output logic [4:0]  d_source,
   output logic        d_denied,
   output logic [31:0] d_data,
   output logic        d_corrupt
);

   localparam int unsigned W  = $clog2(DEPTH_WORDS * 4);
   localparam int unsigned IW = W - 2;

`ifdef TL_UL_RESP_DENY_EN
   localparam logic DenyEn = 1'b1;
`else
   localparam logic DenyEn = 1'b0;
`endif

   typedef struct packed {
      logic [2:0]  opcode;
      logic [3:0]  size;
      logic [4:0]  source;
      logic        denied;
      logic [31:0] data;
      logic        corrupt;
   } RespEntryT;

   logic [31:0] memArray [DEPTH_WORDS];

   RespEntryT   queue_q [2];
   logic [1:0]  count_q, count_d;
   logic        head_q, head_d;
   logic        tail_q, tail_d;

   logic        aFire, dFire;
   logic [IW-1:0] wordIdx;
   logic        inRange, aligned, opLegal, sizeLegal, isLegal;
   logic        isGet, isPut;
   logic [31:0] readWord;
   RespEntryT   newEntry, headEntry;
   logic        unusedParam;

   assign unusedParam = ^a_param;

   assign a_ready = reset_n && (count_q < 2'd2);
   assign d_valid = (count_q != 2'd0);
   assign aFire   = a_valid && a_ready;
   assign dFire   = d_valid && d_ready;

   assign wordIdx   = a_address[W-1:2];
   assign inRange   = (a_address[31:W] == BASE_ADDR[31:W]);
   assign opLegal   = (a_opcode == 3'd0) || (a_opcode == 3'd1) || (a_opcode == 3'd4);
   assign sizeLegal = (a_size <= 4'd2);
   assign isGet     = (a_opcode == 3'd4);
   assign isPut     = (a_opcode == 3'd0) || (a_opcode == 3'd1);
   assign isLegal   = opLegal && sizeLegal && aligned && inRange;
   assign readWord  = memArray[wordIdx];

   // Natural alignment check for the requested transfer size
   always_comb begin
      aligned = 1'b0;
      case (a_size)
         4'd0:    aligned = 1'b1;
         4'd1:    aligned = ~a_address[0];
         4'd2:    aligned = (a_address[1:0] == 2'b00);
         default: aligned = 1'b0;
      endcase
   end

   // Build the response captured at the A fire edge
   always_comb begin
      newEntry         = '0;
      newEntry.opcode  = isGet ? 3'd1 : 3'd0;
      newEntry.size    = a_size;
      newEntry.source  = a_source;
      newEntry.denied  = !isLegal && DenyEn;
      newEntry.data    = (isGet && isLegal) ? readWord : 32'h0;
      newEntry.corrupt = !isLegal && DenyEn && isGet;
   end

   // Queue pointer and occupancy bookkeeping
   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (aFire) begin
         tail_d = ~tail_q;
      end
      if (dFire) begin
         head_d = ~head_q;
      end
      case ({aFire, dFire})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Response queue state; reset drops any pending responses
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q    <= 2'd0;
         head_q     <= 1'b0;
         tail_q     <= 1'b0;
         queue_q[0] <= '0;
         queue_q[1] <= '0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         if (aFire) begin
            queue_q[tail_q] <= newEntry;
         end
      end
   end

   // Byte-lane writes for legal, uncorrupted Puts; the array is never reset
   always_ff @(posedge clock) begin
      if (aFire && isPut && isLegal && !a_corrupt) begin
         for (int b = 0; b < 4; b++) begin
            if (a_mask[b]) begin
               memArray[wordIdx][8*b +: 8] <= a_data[8*b +: 8];
            end
         end
      end
   end

   assign headEntry = queue_q[head_q];

   assign d_opcode  = d_valid ? headEntry.opcode  : 3'd0;
   assign d_param   = 2'd0;
   assign d_size    = d_valid ? headEntry.size    : 4'd0;
   assign d_source  = d_valid ? headEntry.source  : 5'd0;
   assign d_denied  = d_valid ? headEntry.denied  : 1'b0;
   assign d_data    = d_valid ? headEntry.data    : 32'h0;
   assign d_corrupt = d_valid ? headEntry.corrupt : 1'b0;

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// Testbench for tl_ul_sram_responder: directed steps plus random traffic
// against a behavioural model of memory contents and the in-order response list.
module tb_tl_ul_sram_responder;

   localparam logic [31:0] BaseAddr   = 32'h0800_0000;
   localparam int          DepthWords = 256;

`ifdef TL_UL_RESP_DENY_EN
   localparam logic DenyEn = 1'b1;
`else
   localparam logic DenyEn = 1'b0;
`endif

   typedef struct packed {
      logic [2:0]  opcode;
      logic [3:0]  size;
      logic [4:0]  source;
      logic        denied;
      logic [31:0] data;
      logic        corrupt;
   } RespT;

   logic        clock;
   logic        reset_n;
   logic        a_valid;
   logic        a_ready;
   logic [2:0]  a_opcode;
   logic [2:0]  a_param;
   logic [3:0]  a_size;
   logic [4:0]  a_source;
   logic [31:0] a_address;
   logic [3:0]  a_mask;
   logic [31:0] a_data;
   logic        a_corrupt;
   logic        d_valid;
   logic        d_ready;
   logic [2:0]  d_opcode;
   logic [1:0]  d_param;
   logic [3:0]  d_size;
   logic [4:0]  d_source;
   logic        d_denied;
   logic [31:0] d_data;
   logic        d_corrupt;

   int          testsRun  = 0;
   int          failCount = 0;
   int          cycleNum  = 0;
   bit          resetActive;
   bit          lastAFire;
   bit          lastDFire;
   logic [4:0]  lastDSource;
   RespT        modelQ [$];
   logic [31:0] memModel [DepthWords];

   tl_ul_sram_responder #(
      .BASE_ADDR   (BaseAddr),
      .DEPTH_WORDS (DepthWords)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .a_opcode  (a_opcode),
      .a_param   (a_param),
      .a_size    (a_size),
      .a_source  (a_source),
      .a_address (a_address),
      .a_mask    (a_mask),
      .a_data    (a_data),
      .a_corrupt (a_corrupt),
      .d_valid   (d_valid),
      .d_ready   (d_ready),
      .d_opcode  (d_opcode),
      .d_param   (d_param),
      .d_size    (d_size),
      .d_source  (d_source),
      .d_denied  (d_denied),
      .d_data    (d_data),
      .d_corrupt (d_corrupt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] initWord(input int i);
      return 32'hA5C3_0000 ^ 32'(i * 66051);
   endfunction

   function automatic bit isLegalReq(input logic [2:0] op, input logic [3:0] sz,
                                     input logic [31:0] addr);
      longint a;
      longint bytes;
      a = longint'(addr);
      if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) return 1'b0;
      if (sz > 4'd2) return 1'b0;
      bytes = longint'(1) << sz;
      if ((a % bytes) != 0) return 1'b0;
      if (a < longint'(BaseAddr) || a >= longint'(BaseAddr) + DepthWords * 4) return 1'b0;
      return 1'b1;
   endfunction

   function automatic RespT modelResp(input logic [2:0] op, input logic [3:0] sz,
                                      input logic [4:0] src, input logic [31:0] addr);
      RespT r;
      bit   legal;
      int   idx;
      legal     = isLegalReq(op, sz, addr);
      r         = '0;
      r.opcode  = (op == 3'd4) ? 3'd1 : 3'd0;
      r.size    = sz;
      r.source  = src;
      r.denied  = !legal && DenyEn;
      r.corrupt = !legal && DenyEn && (op == 3'd4);
      if (legal && op == 3'd4) begin
         idx    = int'((addr - BaseAddr) / 4);
         r.data = memModel[idx];
      end
      return r;
   endfunction

   task automatic modelWrite(input logic [2:0] op, input logic [3:0] sz, input logic [31:0] addr,
                             input logic [3:0] mask, input logic [31:0] data, input bit corr);
      int idx;
      if (isLegalReq(op, sz, addr) && (op == 3'd0 || op == 3'd1) && !corr) begin
         idx = int'((addr - BaseAddr) / 4);
         for (int b = 0; b < 4; b++) begin
            if (mask[b]) memModel[idx][8*b +: 8] = data[8*b +: 8];
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      RespT e;
      check("a_ready", 32'(a_ready), 32'(!resetActive && modelQ.size() < 2));
      check("d_param", 32'(d_param), 32'h0);
      if (modelQ.size() > 0) begin
         e = modelQ[0];
         check("d_valid",   32'(d_valid),   32'h1);
         check("d_opcode",  32'(d_opcode),  32'(e.opcode));
         check("d_size",    32'(d_size),    32'(e.size));
         check("d_source",  32'(d_source),  32'(e.source));
         check("d_denied",  32'(d_denied),  32'(e.denied));
         check("d_data",    d_data,         e.data);
         check("d_corrupt", 32'(d_corrupt), 32'(e.corrupt));
      end else begin
         check("d_valid_idle",   32'(d_valid),   32'h0);
         check("d_opcode_idle",  32'(d_opcode),  32'h0);
         check("d_size_idle",    32'(d_size),    32'h0);
         check("d_source_idle",  32'(d_source),  32'h0);
         check("d_denied_idle",  32'(d_denied),  32'h0);
         check("d_data_idle",    d_data,         32'h0);
         check("d_corrupt_idle", 32'(d_corrupt), 32'h0);
      end
   endtask

   task automatic applyStimulus(input bit v, input logic [2:0] op, input logic [3:0] sz,
                                input logic [4:0] src, input logic [31:0] addr,
                                input logic [3:0] mask, input logic [31:0] data,
                                input bit corr, input bit dr);
      bit fireA;
      bit fireD;
      a_valid   = v;
      a_opcode  = op;
      a_param   = 3'($urandom_range(0, 7));
      a_size    = sz;
      a_source  = src;
      a_address = addr;
      a_mask    = mask;
      a_data    = data;
      a_corrupt = corr;
      d_ready   = dr;
      #1;
      checkOutput();
      lastDSource = d_source;
      fireA = v && !resetActive && (modelQ.size() < 2);
      fireD = dr && !resetActive && (modelQ.size() > 0);
      lastAFire = fireA;
      lastDFire = fireD;
      if (fireD) void'(modelQ.pop_front());
      if (fireA) begin
         modelQ.push_back(modelResp(op, sz, src, addr));
         modelWrite(op, sz, addr, mask, data, corr);
      end
      cycleNum++;
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input bit dr);
      applyStimulus(1'b0, 3'd4, 4'd2, 5'd0, BaseAddr, 4'hF, 32'h0, 1'b0, dr);
   endtask

   task automatic request(input logic [2:0] op, input logic [3:0] sz, input logic [4:0] src,
                          input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] data, input bit corr, input bit dr);
      applyStimulus(1'b1, op, sz, src, addr, mask, data, corr, dr);
   endtask

   initial begin
      int          firstD;
      int          acc3;
      logic [4:0]  seen [$];
      logic [2:0]  rOp;
      logic [3:0]  rSz;
      logic [31:0] rAddr;
      int          r;

      reset_n     = 1'b0;
      resetActive = 1'b1;
      a_valid     = 1'b0;
      a_opcode    = 3'd0;
      a_param     = 3'd0;
      a_size      = 4'd0;
      a_source    = 5'd0;
      a_address   = 32'h0;
      a_mask      = 4'h0;
      a_data      = 32'h0;
      a_corrupt   = 1'b0;
      d_ready     = 1'b0;

      // Reset held for three checked cycles, then release
      @(posedge clock);
      #1;
      for (int i = 0; i < 3; i++) idle(1'b0);
      reset_n     = 1'b1;
      resetActive = 1'b0;
      #1;
      check("ready_after_release", 32'(a_ready), 32'h1);

      // Fill the whole array with known contents
      for (int i = 0; i < DepthWords; i++) begin
         request(3'd0, 4'd2, 5'(i), BaseAddr + 32'(i * 4), 4'hF, initWord(i), 1'b0, 1'b1);
      end
      idle(1'b1);

      // Write then read back
      request(3'd0, 4'd2, 5'd5, 32'h0800_0010, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b1);
      check("put_accept", 32'(lastAFire), 32'h1);
      check("put_ack_valid", 32'(d_valid), 32'h1);
      check("put_ack_opcode", 32'(d_opcode), 32'h0);
      check("put_ack_source", 32'(d_source), 32'h5);
      request(3'd4, 4'd2, 5'd7, 32'h0800_0010, 4'hF, 32'h0, 1'b0, 1'b1);
      check("get_opcode", 32'(d_opcode), 32'h1);
      check("get_data", d_data, 32'hDEAD_BEEF);
      check("get_source", 32'(d_source), 32'h7);
      check("get_denied", 32'(d_denied), 32'h0);

      // Partial write merges selected byte lanes
      request(3'd0, 4'd2, 5'd1, 32'h0800_0020, 4'hF, 32'h1122_3344, 1'b0, 1'b1);
      request(3'd1, 4'd2, 5'd2, 32'h0800_0020, 4'h6, 32'hAABB_CCDD, 1'b0, 1'b1);
      request(3'd4, 4'd2, 5'd3, 32'h0800_0020, 4'hF, 32'h0, 1'b0, 1'b1);
      check("partial_data", d_data, 32'h11BB_CC44);
      idle(1'b1);

      // Illegal requests: out of window, misaligned, and a misaligned Put
      request(3'd4, 4'd2, 5'd9, 32'h0900_0000, 4'hF, 32'h0, 1'b0, 1'b1);
      check("oor_denied", 32'(d_denied), 32'(DenyEn));
      check("oor_corrupt", 32'(d_corrupt), 32'(DenyEn));
      check("oor_data", d_data, 32'h0);
      request(3'd4, 4'd2, 5'd10, 32'h0800_0002, 4'hF, 32'h0, 1'b0, 1'b1);
      check("misalign_denied", 32'(d_denied), 32'(DenyEn));
      check("misalign_data", d_data, 32'h0);
      request(3'd0, 4'd2, 5'd12, 32'h0800_0001, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b1);
      check("bad_put_denied", 32'(d_denied), 32'(DenyEn));
      request(3'd4, 4'd2, 5'd11, 32'h0800_0000, 4'hF, 32'h0, 1'b0, 1'b1);
      check("word0_unchanged", d_data, initWord(0));
      check("word0_denied", 32'(d_denied), 32'h0);

      // Poisoned Put is acked but leaves memory alone
      request(3'd0, 4'd2, 5'd13, 32'h0800_0004, 4'hF, 32'h1234_5678, 1'b1, 1'b1);
      check("corrupt_put_denied", 32'(d_denied), 32'h0);
      request(3'd4, 4'd2, 5'd14, 32'h0800_0004, 4'hF, 32'h0, 1'b0, 1'b1);
      check("corrupt_put_nowrite", d_data, initWord(1));
      idle(1'b1);

      // Backpressure: two accepts fill the queue, third waits
      request(3'd4, 4'd2, 5'd1, 32'h0800_0010, 4'hF, 32'h0, 1'b0, 1'b0);
      check("bp_accept1", 32'(lastAFire), 32'h1);
      request(3'd4, 4'd2, 5'd2, 32'h0800_0020, 4'hF, 32'h0, 1'b0, 1'b0);
      check("bp_accept2", 32'(lastAFire), 32'h1);
      check("bp_full_ready", 32'(a_ready), 32'h0);
      for (int k = 0; k < 2; k++) begin
         request(3'd4, 4'd2, 5'd3, 32'h0800_0000, 4'hF, 32'h0, 1'b0, 1'b0);
         check("bp_stall_noaccept", 32'(lastAFire), 32'h0);
         check("bp_head_source", 32'(d_source), 32'h1);
         check("bp_head_data", d_data, 32'hDEAD_BEEF);
      end
      firstD = -1;
      acc3   = -1;
      for (int k = 0; k < 8; k++) begin
         applyStimulus(acc3 < 0, 3'd4, 4'd2, 5'd3, 32'h0800_0000, 4'hF, 32'h0, 1'b0, 1'b1);
         if (lastDFire) begin
            seen.push_back(lastDSource);
            if (firstD < 0) firstD = cycleNum;
         end
         if (lastAFire && acc3 < 0) acc3 = cycleNum;
      end
      check("bp_accept_gap", 32'(acc3 - firstD), 32'h1);
      check("bp_resp_count", 32'(seen.size()), 32'h3);
      for (int i = 0; i < 3; i++) begin
         check("bp_order", (i < seen.size()) ? 32'(seen[i]) : 32'hFF, 32'(i + 1));
      end

      // Reset with two pending responses
      request(3'd4, 4'd2, 5'd20, 32'h0800_0010, 4'hF, 32'h0, 1'b0, 1'b0);
      request(3'd4, 4'd2, 5'd21, 32'h0800_0020, 4'hF, 32'h0, 1'b0, 1'b0);
      check("mid_pending_valid", 32'(d_valid), 32'h1);
      reset_n     = 1'b0;
      resetActive = 1'b1;
      modelQ.delete();
      #1;
      check("mid_rst_dvalid", 32'(d_valid), 32'h0);
      check("mid_rst_ready", 32'(a_ready), 32'h0);
      idle(1'b0);
      reset_n     = 1'b1;
      resetActive = 1'b0;
      idle(1'b1);
      request(3'd4, 4'd2, 5'd22, 32'h0800_0010, 4'hF, 32'h0, 1'b0, 1'b1);
      check("mid_rst_mem_kept", d_data, 32'hDEAD_BEEF);
      check("mid_rst_source", 32'(d_source), 32'd22);

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         r = int'($urandom_range(0, 9));
         if (r < 3)      rOp = 3'd4;
         else if (r < 5) rOp = 3'd0;
         else if (r < 8) rOp = 3'd1;
         else            rOp = 3'($urandom_range(0, 7));
         r = int'($urandom_range(0, 11));
         if (r < 8)       rSz = 4'd2;
         else if (r < 11) rSz = 4'($urandom_range(0, 1));
         else             rSz = 4'($urandom_range(3, 15));
         rAddr = BaseAddr + 32'($urandom_range(0, DepthWords - 1) * 4);
         if (rSz == 4'd0) rAddr = rAddr + 32'($urandom_range(0, 3));
         if (rSz == 4'd1) rAddr = rAddr + 32'($urandom_range(0, 1) * 2);
         r = int'($urandom_range(0, 19));
         if (r == 0)      rAddr = $urandom;
         else if (r == 1) rAddr = rAddr + 32'd1;
         applyStimulus($urandom_range(0, 4) != 0, rOp, rSz, 5'($urandom_range(0, 31)), rAddr,
                       4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 9) == 0,
                       $urandom_range(0, 3) != 0);
      end
      for (int i = 0; i < 3; i++) idle(1'b1);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
